// File: rtl/seg_disp_pkg.sv
// Shared constants and glyph table for the seven-segment display driver.
// All patterns are active-low cathodes, bit 0 = segment a ... bit 6 = segment g.
package seg_disp_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    localparam seg7_t SEG7_DIGIT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [7:0] seg_cathodes(seg7_t pat, logic dp_on);
        return {~dp_on, pat};
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase for the display mux: slot prescaler and digit index.
// Emits slot wrap, frame boundary, dead-window flag and PWM phase.
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIV_BITS    = 17,
    parameter int DEAD_CYCLES = 64,
    parameter int BRIGHT_W    = 4,
    parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                ck,
    input  logic                rst_n,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_slot_wrap,
    output logic                o_frame,
    output logic                o_dead,
    output logic [BRIGHT_W-1:0] o_phase
);

    logic [DIV_BITS-1:0] r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic                w_last_digit;

    assign o_slot_wrap  = &r_pre;
    assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= r_pre + DIV_BITS'(1);
            if (o_slot_wrap) begin
                r_idx <= w_last_digit ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign o_idx   = r_idx;
    assign o_frame = (r_idx == '0) && (r_pre == '0);
    assign o_dead  = (r_pre < DIV_BITS'(DEAD_CYCLES));
    assign o_phase = r_pre[DIV_BITS-1 -: BRIGHT_W];

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered data.
// Define SEG_PWM_EN to enable brightness PWM; otherwise digits are lit all slot.
module seg_display_mux
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIV_BITS    = 17,
    parameter int DEAD_CYCLES = 64,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic [7*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [IDX_W-1:0]    w_idx;
    logic                w_slot_wrap;
    logic                w_frame;
    logic                w_dead;
    logic [BRIGHT_W-1:0] w_phase;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIV_BITS    (DIV_BITS),
        .DEAD_CYCLES (DEAD_CYCLES),
        .BRIGHT_W    (BRIGHT_W),
        .IDX_W       (IDX_W)
    ) u_timer (
        .ck          (ck),
        .rst_n       (rst_n),
        .o_idx       (w_idx),
        .o_slot_wrap (w_slot_wrap),
        .o_frame     (w_frame),
        .o_dead      (w_dead),
        .o_phase     (w_phase)
    );

    logic [NUM_DIGITS-1:0][6:0] r_sh_dig;
    logic [NUM_DIGITS-1:0][6:0] r_act_dig;
    logic [NUM_DIGITS-1:0]      r_sh_dp;
    logic [NUM_DIGITS-1:0]      r_act_dp;
    logic [NUM_DIGITS-1:0]      r_sh_blank;
    logic [NUM_DIGITS-1:0]      r_act_blank;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_dig    <= {NUM_DIGITS{SEG7_BLANK}};
            r_sh_dp     <= '0;
            r_sh_blank  <= '1;
            r_act_dig   <= {NUM_DIGITS{SEG7_BLANK}};
            r_act_dp    <= '0;
            r_act_blank <= '1;
        end else begin
            if (load) begin
                r_sh_dig   <= digits;
                r_sh_dp    <= dp;
                r_sh_blank <= blank;
            end
            if (w_frame) begin
                r_act_dig   <= r_sh_dig;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
            end
        end
    end

    // At the boundary the active copy is still stale, so read the shadow.
    logic [NUM_DIGITS-1:0][6:0] w_src_dig;
    logic [NUM_DIGITS-1:0]      w_src_dp;
    logic [NUM_DIGITS-1:0]      w_src_blank;

    assign w_src_dig   = w_frame ? r_sh_dig   : r_act_dig;
    assign w_src_dp    = w_frame ? r_sh_dp    : r_act_dp;
    assign w_src_blank = w_frame ? r_sh_blank : r_act_blank;

    seg7_t w_pat;
    logic  w_dp;
    logic  w_blk;

    assign w_pat = w_src_dig[w_idx];
    assign w_dp  = w_src_dp[w_idx];
    assign w_blk = w_src_blank[w_idx];

    logic w_pwm_on;
    logic w_unused;

`ifdef SEG_PWM_EN
    assign w_pwm_on = (brightness == '1) || (w_phase < brightness);
    assign w_unused = w_slot_wrap;
`else
    assign w_pwm_on = 1'b1;
    assign w_unused = ^{w_slot_wrap, w_phase, brightness};
`endif

    logic                  w_lit;
    logic [7:0]            w_seg_n;
    logic [NUM_DIGITS-1:0] w_an_n;

    always_comb begin
        w_seg_n = SEG_OFF;
        w_an_n  = '1;
        w_lit   = !w_dead && w_pwm_on && !w_blk;
        if (!w_dead && !w_blk) begin
            w_seg_n = seg_cathodes(w_pat, w_dp);
        end
        if (w_lit) begin
            w_an_n[w_idx] = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_OFF;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            seg         <= w_seg_n;
            an          <= w_an_n;
            frame_start <= w_frame;
        end
    end

endmodule
